// File: rtl/tlb_params.sv
// Shared TLB types: operation codes, sequencer state, and the entry /
// search port structures used between CP0, the sequencer and the tlb core.
package tlb_params;

    localparam int VPN2_W    = 19;
    localparam int ASID_W    = 8;
    localparam int PFN_W     = 20;
    localparam int IDX_W_MAX = 8;

    typedef enum logic [1:0] {
        TLBP  = 2'd0,
        TLBR  = 2'd1,
        TLBWI = 2'd2,
        TLBWR = 2'd3
    } tlb_op_t;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_EXEC = 2'd1,
        SEQ_RESP = 2'd2
    } tlb_seq_state_t;

    // EntryHi / EntryLo0 / EntryLo1 contents as one TLB entry
    typedef struct packed {
        logic [VPN2_W-1:0] vpn2;
        logic [ASID_W-1:0] asid;
        logic [PFN_W-1:0]  pfn0;
        logic [2:0]        c0;
        logic              d0;
        logic              v0;
        logic [PFN_W-1:0]  pfn1;
        logic [2:0]        c1;
        logic              d1;
        logic              v1;
        logic              g;
    } tlb_request_t;

    typedef struct packed {
        logic [VPN2_W-1:0] vpn2;
        logic              odd_page;
        logic [ASID_W-1:0] asid;
    } search_request_t;

    typedef struct packed {
        logic                 found;
        logic [IDX_W_MAX-1:0] index;
    } search_result_t;

endpackage

// File: rtl/tlb_random_counter.sv
// CP0 Random register with Wired handling. Only built when
// TLB_WRITE_RANDOM_EN is defined; otherwise the sequencer ties Random to 0.
`ifdef TLB_WRITE_RANDOM_EN
module tlb_random_counter #(
    parameter int  TLB_NUM = 16,
    localparam int IW      = $clog2(TLB_NUM)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [IW-1:0] cp0_wired,
    input  logic          wired_written,
    output logic [IW-1:0] random
);

    localparam logic [IW-1:0] TOP = IW'(TLB_NUM - 1);

    // Count down toward Wired, reloading to the top on wrap, on a Wired
    // write, or when Wired leaves no random range at all.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            random <= TOP;
        else if (wired_written || cp0_wired >= TOP || random <= cp0_wired)
            random <= TOP;
        else
            random <= random - 1'b1;
    end

endmodule
`endif

// File: rtl/tlb_op_sequencer.sv
// Three-state sequencer running TLBP/TLBR/TLBWI/TLBWR against the tlb core.
// Optional feature macro: TLB_WRITE_RANDOM_EN (Random register and TLBWR
// targeting Random); when undefined TLBWR behaves as TLBWI.
module tlb_op_sequencer
    import tlb_params::*;
#(
    parameter int  TLB_NUM = 16,
    localparam int IW      = $clog2(TLB_NUM)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            op_valid,
    output logic            op_ready,
    input  tlb_op_t         op_code,
    input  tlb_request_t    cp0_entry,
    input  logic [IW-1:0]   cp0_index,
    input  logic [IW-1:0]   cp0_wired,
    input  logic            wired_written,
    output logic            done_valid,
    output logic            index_we,
    output logic [IW:0]     index_wdata,
    output logic            entry_we,
    output tlb_request_t    entry_wdata,
    output logic [IW-1:0]   random,
    output search_request_t tlb_search_request,
    input  search_result_t  tlb_search_result,
    output logic            tlb_write_enabled,
    output logic [IW-1:0]   tlb_write_index,
    output tlb_request_t    tlb_write_data,
    output logic [IW-1:0]   tlb_read_index,
    input  tlb_request_t    tlb_read_data
);

    tlb_seq_state_t state;
    tlb_op_t        op_q;
    tlb_request_t   entry_q;
    logic [IW-1:0]  index_q;
    logic [IW-1:0]  target_q;
    logic [IW-1:0]  wr_target;
    logic [IW:0]    pidx_q;
    tlb_request_t   rd_q;
    logic           accept;

    assign accept = (state == SEQ_IDLE) && op_valid;

`ifdef TLB_WRITE_RANDOM_EN
    tlb_random_counter #(.TLB_NUM(TLB_NUM)) u_random (
        .clock        (clock),
        .reset_n      (reset_n),
        .cp0_wired    (cp0_wired),
        .wired_written(wired_written),
        .random       (random)
    );
    assign wr_target = (op_code == TLBWR) ? random : cp0_index;
`else
    logic unused_random_inputs;
    assign unused_random_inputs = ^{cp0_wired, wired_written};
    assign random    = '0;
    assign wr_target = cp0_index;
`endif

    // Only the low IW bits of the hit index are meaningful here
    logic unused_search_bits;
    assign unused_search_bits = ^tlb_search_result.index;

    // Fixed IDLE -> EXEC -> RESP walk; no back-pressure on the result side
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= SEQ_IDLE;
        end else begin
            case (state)
                SEQ_IDLE: if (op_valid) state <= SEQ_EXEC;
                SEQ_EXEC: state <= SEQ_RESP;
                default:  state <= SEQ_IDLE;
            endcase
        end
    end

    // Latch the request so EXEC sees stable operands regardless of CP0
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= TLBP;
            entry_q  <= '0;
            index_q  <= '0;
            target_q <= '0;
        end else if (accept) begin
            op_q     <= op_code;
            entry_q  <= cp0_entry;
            index_q  <= cp0_index;
            target_q <= wr_target;
        end
    end

    // Capture search / read results at the end of EXEC for the RESP write-back
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pidx_q <= '0;
            rd_q   <= '0;
        end else if (state == SEQ_EXEC) begin
            if (op_q == TLBP)
                pidx_q <= tlb_search_result.found
                          ? {1'b0, tlb_search_result.index[IW-1:0]}
                          : {1'b1, {IW{1'b0}}};
            if (op_q == TLBR)
                rd_q <= tlb_read_data;
        end
    end

    assign op_ready    = (state == SEQ_IDLE);
    assign done_valid  = (state == SEQ_RESP);
    assign index_we    = (state == SEQ_RESP) && (op_q == TLBP);
    assign entry_we    = (state == SEQ_RESP) && (op_q == TLBR);
    assign index_wdata = pidx_q;
    assign entry_wdata = rd_q;

    assign tlb_write_enabled  = (state == SEQ_EXEC) && (op_q == TLBWI || op_q == TLBWR);
    assign tlb_write_index    = target_q;
    assign tlb_write_data     = entry_q;
    assign tlb_read_index     = index_q;
    assign tlb_search_request = '{vpn2: entry_q.vpn2, odd_page: 1'b0, asid: entry_q.asid};

endmodule

// File: tb/tb_tlb_op_sequencer.sv
// Directed bench for tlb_op_sequencer with a behavioural 16-entry TLB model.
module tb_tlb_op_sequencer;
    import tlb_params::*;

    localparam int TLB_NUM = 16;
    localparam int IW      = 4;
`ifdef TLB_WRITE_RANDOM_EN
    localparam logic [IW-1:0] RND_RST = 4'd15;
`else
    localparam logic [IW-1:0] RND_RST = 4'd0;
`endif

    logic            clock = 1'b0;
    logic            reset_n = 1'b1;
    logic            op_valid = 1'b0;
    logic            op_ready;
    tlb_op_t         op_code = TLBP;
    tlb_request_t    cp0_entry = '0;
    logic [IW-1:0]   cp0_index = '0;
    logic [IW-1:0]   cp0_wired = '0;
    logic            wired_written = 1'b0;
    logic            done_valid;
    logic            index_we;
    logic [IW:0]     index_wdata;
    logic            entry_we;
    tlb_request_t    entry_wdata;
    logic [IW-1:0]   random;
    search_request_t tlb_search_request;
    search_result_t  tlb_search_result;
    logic            tlb_write_enabled;
    logic [IW-1:0]   tlb_write_index;
    tlb_request_t    tlb_write_data;
    logic [IW-1:0]   tlb_read_index;
    tlb_request_t    tlb_read_data;

    always #5 clock = ~clock;

    tlb_op_sequencer #(.TLB_NUM(TLB_NUM)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .op_valid          (op_valid),
        .op_ready          (op_ready),
        .op_code           (op_code),
        .cp0_entry         (cp0_entry),
        .cp0_index         (cp0_index),
        .cp0_wired         (cp0_wired),
        .wired_written     (wired_written),
        .done_valid        (done_valid),
        .index_we          (index_we),
        .index_wdata       (index_wdata),
        .entry_we          (entry_we),
        .entry_wdata       (entry_wdata),
        .random            (random),
        .tlb_search_request(tlb_search_request),
        .tlb_search_result (tlb_search_result),
        .tlb_write_enabled (tlb_write_enabled),
        .tlb_write_index   (tlb_write_index),
        .tlb_write_data    (tlb_write_data),
        .tlb_read_index    (tlb_read_index),
        .tlb_read_data     (tlb_read_data)
    );

    // Behavioural TLB: synchronous write, combinational read and search
    tlb_request_t mem [TLB_NUM];

    always @(posedge clock)
        if (tlb_write_enabled) mem[tlb_write_index] <= tlb_write_data;

    assign tlb_read_data = mem[tlb_read_index];

    always_comb begin
        tlb_search_result = '0;
        for (int i = TLB_NUM - 1; i >= 0; i--)
            if (mem[i].vpn2 == tlb_search_request.vpn2 &&
                (mem[i].g || mem[i].asid == tlb_search_request.asid)) begin
                tlb_search_result.found = 1'b1;
                tlb_search_result.index = 8'(i);
            end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic tlb_request_t mk(input logic [18:0] vpn2, input logic [7:0] asid,
                                        input logic [19:0] pfn0, input logic [19:0] pfn1,
                                        input logic g);
        tlb_request_t e;
        e = '0;
        e.vpn2 = vpn2; e.asid = asid; e.pfn0 = pfn0; e.pfn1 = pfn1; e.g = g;
        e.c0 = 3'd3; e.d0 = 1'b1; e.v0 = 1'b1;
        e.c1 = 3'd2; e.d1 = 1'b0; e.v1 = 1'b1;
        return e;
    endfunction

    // Observations from the last run_op
    logic          ex_ready, ex_we;
    logic [IW-1:0] ex_widx;
    tlb_request_t  ex_wdata;
    logic          rs_done, rs_iwe, rs_ewe, rs_we;
    logic [IW:0]   rs_iw;
    tlb_request_t  rs_ew;

    // Called aligned 1ns after a rising edge; returns aligned, back in IDLE
    task automatic run_op(input tlb_op_t op, input tlb_request_t e, input logic [IW-1:0] idx);
        int n = 0;
        while (!op_ready && n < 20) begin @(posedge clock); #1; n++; end
        if (!op_ready) chk("ready_timeout", 0, 1);
        op_valid = 1'b1; op_code = op; cp0_entry = e; cp0_index = idx;
        @(posedge clock); #1;
        op_valid = 1'b0;
        ex_ready = op_ready; ex_we = tlb_write_enabled;
        ex_widx = tlb_write_index; ex_wdata = tlb_write_data;
        @(posedge clock); #1;
        rs_done = done_valid; rs_iwe = index_we; rs_ewe = entry_we; rs_we = tlb_write_enabled;
        rs_iw = index_wdata; rs_ew = entry_wdata;
        @(posedge clock); #1;
    endtask

    tlb_request_t e1, e2, e3, e4, probe;
    logic [6:0] rdy_pat, done_pat;
    logic [IW-1:0] wr_exp;

    initial begin
        for (int i = 0; i < TLB_NUM; i++) mem[i] = '0;
        e1 = mk(19'h12345, 8'h3A, 20'hABCDE, 20'h13579, 1'b0);
        e2 = mk(19'h00777, 8'h11, 20'h22222, 20'h33333, 1'b0);
        e3 = mk(19'h7FFFF, 8'hFF, 20'hFFFFF, 20'h0F0F0, 1'b1);
        e4 = mk(19'h2468A, 8'h05, 20'h55555, 20'h66666, 1'b0);

        // Reset state
        #1 reset_n = 1'b0;
        #2;
        chk("rst_ready", op_ready, 1);
        chk("rst_random", random, RND_RST);
        chk("rst_done", done_valid, 0);
        chk("rst_index_we", index_we, 0);
        chk("rst_entry_we", entry_we, 0);
        chk("rst_write_en", tlb_write_enabled, 0);
        chk("rst_index_wdata", index_wdata, 0);
        chk("rst_entry_wdata", entry_wdata, 0);
        chk("rst_write_index", tlb_write_index, 0);
        chk("rst_read_index", tlb_read_index, 0);
        @(posedge clock); @(posedge clock); #1;
        reset_n = 1'b1;

        // TLBWI index 5
        run_op(TLBWI, e1, 4'd5);
        chk("wi_exec_ready", ex_ready, 0);
        chk("wi_exec_we", ex_we, 1);
        chk("wi_exec_idx", ex_widx, 5);
        chk("wi_exec_data", ex_wdata, e1);
        chk("wi_resp_done", rs_done, 1);
        chk("wi_resp_we", rs_we, 0);
        chk("wi_resp_iwe", rs_iwe, 0);
        chk("wi_resp_ewe", rs_ewe, 0);

        // TLBP hit
        run_op(TLBP, e1, 4'd0);
        chk("p_hit_exec_we", ex_we, 0);
        chk("p_hit_done", rs_done, 1);
        chk("p_hit_iwe", rs_iwe, 1);
        chk("p_hit_wdata", rs_iw, 5'h05);

        // TLBP miss on ASID
        probe = e1; probe.asid = 8'h3B; probe.g = 1'b0;
        run_op(TLBP, probe, 4'd0);
        chk("p_miss_iwe", rs_iwe, 1);
        chk("p_miss_wdata", rs_iw, 5'h10);

        // TLBR index 5
        run_op(TLBR, '0, 4'd5);
        chk("r_ewe", rs_ewe, 1);
        chk("r_iwe", rs_iwe, 0);
        chk("r_data", rs_ew, e1);

        // Random / Wired
        cp0_wired = 4'd4; wired_written = 1'b1;
        @(posedge clock); #1;
        wired_written = 1'b0;
        chk("rnd_wired_load", random, RND_RST);
`ifdef TLB_WRITE_RANDOM_EN
        for (int v = 14; v >= 4; v--) begin
            @(posedge clock); #1;
            chk("rnd_count", random, v);
        end
        @(posedge clock); #1;
        chk("rnd_wrap", random, 15);
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("rnd_after_wrap", random, 13);
        wired_written = 1'b1;
        @(posedge clock); #1;
        wired_written = 1'b0;
        chk("rnd_wired_mid", random, 15);
        for (int n = 0; n < 20 && random != 4'd9; n++) begin @(posedge clock); #1; end
        chk("rnd_reach9", random, 9);
        wr_exp = 4'd9;
`else
        @(posedge clock); #1;
        chk("rnd_tied", random, 0);
        wr_exp = 4'd7;
`endif
        run_op(TLBWR, e4, 4'd7);
        chk("wr_exec_we", ex_we, 1);
        chk("wr_exec_idx", ex_widx, wr_exp);
        chk("wr_resp_iwe", rs_iwe, 0);
        run_op(TLBR, '0, wr_exp);
        chk("wr_readback", rs_ew, e4);

        // Back-to-back: op_valid held high
        rdy_pat  = 7'b0100100;   // bit k = expected op_ready after edge k (LSB first)
        done_pat = 7'b0010010;
        op_valid = 1'b1; op_code = TLBWI; cp0_entry = e2; cp0_index = 4'd2;
        for (int k = 0; k < 7; k++) begin
            @(posedge clock); #1;
            chk("b2b_ready", op_ready, rdy_pat[k]);
            chk("b2b_done", done_valid, done_pat[k]);
        end
        op_valid = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        chk("b2b_idle", op_ready, 1);
        run_op(TLBR, '0, 4'd2);
        chk("b2b_readback", rs_ew, e2);

        // Reset during EXEC of a TLBWI drops the write
        op_valid = 1'b1; op_code = TLBWI; cp0_entry = e3; cp0_index = 4'd5;
        @(posedge clock); #1;
        op_valid = 1'b0;
        chk("rx_exec_we", tlb_write_enabled, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rx_we_drop", tlb_write_enabled, 0);
        chk("rx_ready", op_ready, 1);
        @(posedge clock); #1;
        chk("rx_no_done", done_valid, 0);
        chk("rx_no_iwe", index_we | entry_we, 0);
        reset_n = 1'b1;
        run_op(TLBR, '0, 4'd5);
        chk("rx_old_contents", rs_ew, e1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlb_op_sequencer.md
# tlb_op_sequencer

Multi-cycle sequencer that executes the four MIPS TLB instructions (TLBP, TLBR, TLBWI, TLBWR) against the `tlb` core. It sits between the CP0 register file / pipeline exception stage and the `tlb` write, read and search ports. It owns the Random register and returns results to CP0 as one-cycle write-back pulses. Search port 1 of `tlb` is dedicated to this block; port 0 stays with instruction fetch.

## Interface
- `TLB_NUM`, 16, number of TLB entries; power of two, ≥ 4; `IW = $clog2(TLB_NUM)`

- `clock`  in  1  sole clock
- `reset_n`  in  1  asynchronous, active-low reset
- `op_valid`  in  1  operation request
- `op_ready`  out  1  sequencer idle; request accepted when `op_valid && op_ready`
- `op_code`  in  `tlb_params::tlb_op_t` (2)  0 TLBP, 1 TLBR, 2 TLBWI, 3 TLBWR
- `cp0_entry`  in  `tlb_params::tlb_request_t`  EntryHi/EntryLo0/EntryLo1 contents
- `cp0_index`  in  IW  Index register entry field
- `cp0_wired`  in  IW  Wired register
- `wired_written`  in  1  one-cycle pulse: CP0 wrote Wired
- `done_valid`  out  1  one-cycle completion pulse
- `index_we`  out  1  write Index (TLBP only)
- `index_wdata`  out  1+IW  `{P, index}`
- `entry_we`  out  1  write EntryHi/EntryLo0/EntryLo1 (TLBR only)
- `entry_wdata`  out  `tlb_request_t`  entry read from TLB
- `random`  out  IW  current Random value
- `tlb_search_request`  out  `search_request_t`  to `tlb` request2
- `tlb_search_result`  in  `search_result_t`  from `tlb` responce2
- `tlb_write_enabled`  out  1;  `tlb_write_index`  out  IW;  `tlb_write_data`  out  `tlb_request_t`
- `tlb_read_index`  out  IW;  `tlb_read_data`  in  `tlb_request_t`

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: `op_ready`=1. On accept, latch `op_code`, `cp0_entry`, `cp0_index`, and the target index (`cp0_index` for TLBWI/TLBR, `random` for TLBWR). Go to EXEC.
- EXEC, one cycle, driven from the latched registers:
  - TLBP: `tlb_search_request` = {vpn2, odd_page=0, asid} from latched entry; capture `found`/`index` at the clock edge.
  - TLBR: `tlb_read_index` = latched index; capture `tlb_read_data`.
  - TLBWI/TLBWR: `tlb_write_enabled`=1, `tlb_write_index` = latched target, `tlb_write_data` = latched entry.
  - Go to RESP.
- RESP: `done_valid`=1. Go to IDLE.
  - TLBP: `index_we`=1. Hit gives `index_wdata` = {0, hit index}; miss gives {1, 0}.
  - TLBR: `entry_we`=1, `entry_wdata` = captured entry.
  - Writes: no CP0 write-back.
- `tlb_write_enabled` is asserted only in EXEC of TLBWI/TLBWR, never otherwise.
- Outside EXEC, the search/read index outputs hold their last value; they are don't-care to `tlb`.
- Random:
  - Decrements every cycle. When it is ≤ `cp0_wired` it reloads to TLB_NUM-1 on the next cycle instead of decrementing (wrap).
  - If `cp0_wired` ≥ TLB_NUM-1, Random holds at TLB_NUM-1.
  - `wired_written` forces Random to TLB_NUM-1 next cycle, with priority over the decrement.
  - The TLBWR target is Random's value in the accept cycle.
- `op_valid` while not IDLE: ignored, `op_ready`=0. Requesters must hold `op_valid` until accepted.
- Unknown `op_code`: cannot occur (2-bit, all encodings defined).

## Timing
- Accept in cycle N; TLB access in N+1; `done_valid` and write-backs in N+2. Next accept is possible in N+3. Fixed latency of 2, throughput of 1 op per 3 cycles.
- Writes land in the TLB at the end of N+1. A TLBP accepted in N+3 observes them.
- Reset values:
  - state IDLE, `op_ready`=1, `random`=TLB_NUM-1.
  - `done_valid`, `index_we`, `entry_we`, `tlb_write_enabled` = 0.
  - All data/index outputs = 0.
- Reset asserted mid-operation aborts immediately and asynchronously: no write-back. A write in EXEC is dropped if reset is asserted before the edge.

## Configuration
- `TLB_WRITE_RANDOM_EN` defined: Random register, `random` output, `cp0_wired` and `wired_written` handling, and TLBWR are all present.
- Undefined:
  - No Random logic; `random` is tied to 0.
  - `cp0_wired` and `wired_written` are ignored.
  - TLBWR is executed as TLBWI, writing `cp0_index`.

## Structure
- In `tlb_params`: `tlb_op_t` enum (TLBP=0, TLBR=1, TLBWI=2, TLBWR=3) and `tlb_seq_state_t` enum. Existing `search_request_t`, `search_result_t` and `tlb_request_t` are reused.
- One sub-module: `tlb_random_counter` (Random/Wired logic, compiled only under `TLB_WRITE_RANDOM_EN`).

## Test plan
- Reset: `reset_n` low → `op_ready`=1, `random`=15, all strobes 0 (TLB_NUM=16).
- TLBWI with `cp0_index`=5, vpn2=0x12345, asid=0x3A → write strobe in N+1 at index 5. Follow with TLBP of the same vpn2/asid → `index_wdata`={0,5} in N+2. TLBP with asid=0x3B, g=0 → {1,0}.
- TLBR with index 5 after the above → `entry_we`=1, `entry_wdata` equals the written entry bit-for-bit.
- Random with `cp0_wired`=4: 15,14,…,4,15 wraps. `wired_written` pulse mid-count → 15 next cycle. TLBWR accepted when `random`=9 writes index 9.
- Back-to-back `op_valid` held high → accepts spaced exactly 3 cycles, `op_ready` low in EXEC/RESP.
- Reset asserted during EXEC of TLBWI → `tlb_write_enabled` drops immediately, no `done_valid`, and a later TLBR of that index returns the old contents.
